// File: rtl/kamacore_scoreboard_pkg.sv
// Shared constants and types for the kamacore decode-stage scoreboard.
//   REG_COUNT / REG_ADDR_WIDTH : architectural register file geometry
//   DEFAULT_CNT_WIDTH          : default width of a per-register in-flight counter
//   sb_state_t                 : issue controller state
package kamacore_scoreboard_pkg;

    localparam int unsigned REG_COUNT         = 32;
    localparam int unsigned REG_ADDR_WIDTH    = 5;
    localparam int unsigned DEFAULT_CNT_WIDTH = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } sb_state_t;

endpackage

// File: rtl/kamacore_scoreboard_if.sv
// Decode/execute/writeback handshake bundle seen by the scoreboard.
//   master : decode/pipeline side (drives id_*, ex_ready, wb_*, flush)
//   slave  : scoreboard side (drives id_ready, issue, stall, stall_cnt, sb_err)
interface kamacore_scoreboard_if #(
    parameter int unsigned STALL_CNT_WIDTH = 16
);
    import kamacore_scoreboard_pkg::*;

    logic                       id_valid;
    logic                       id_rs1_used;
    logic [REG_ADDR_WIDTH-1:0]  id_rs1_a;
    logic                       id_rs2_used;
    logic [REG_ADDR_WIDTH-1:0]  id_rs2_a;
    logic                       id_rd_we;
    logic [REG_ADDR_WIDTH-1:0]  id_rd_a;
    logic                       ex_ready;
    logic                       wb_rd_we;
    logic [REG_ADDR_WIDTH-1:0]  wb_rd_a;
    logic                       flush;
    logic                       id_ready;
    logic                       issue;
    logic                       stall;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt;
    logic                       sb_err;

    modport master (
        output id_valid, id_rs1_used, id_rs1_a, id_rs2_used, id_rs2_a,
               id_rd_we, id_rd_a, ex_ready, wb_rd_we, wb_rd_a, flush,
        input  id_ready, issue, stall, stall_cnt, sb_err
    );

    modport slave (
        input  id_valid, id_rs1_used, id_rs1_a, id_rs2_used, id_rs2_a,
               id_rd_we, id_rd_a, ex_ready, wb_rd_we, wb_rd_a, flush,
        output id_ready, issue, stall, stall_cnt, sb_err
    );

endinterface

// File: rtl/kamacore_scoreboard_sb_counter.sv
// Per-register in-flight write counter.
//   clk, rst  : clock, async active-low reset
//   inc, dec  : issue of a write / retire of a write
//   clear     : flush, forces the count to zero
//   is_zero, is_max, is_one : count status
//   underflow : retire seen while the count is zero
module kamacore_sb_counter #(
    parameter int unsigned W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clear,
    output logic is_zero,
    output logic is_max,
    output logic is_one,
    output logic underflow
);

    logic [W-1:0] cnt_q;
    logic         dec_ok;

    assign is_zero   = (cnt_q == '0);
    assign is_max    = &cnt_q;
    assign is_one    = (cnt_q == W'(1));
    assign underflow = dec & is_zero;
    // a retire against an empty counter is dropped, not wrapped
    assign dec_ok    = dec & ~is_zero;

    // inc and a valid dec together cancel; inc is never taken past max
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (inc && !dec_ok && !is_max) begin
            cnt_q <= cnt_q + W'(1);
        end else if (dec_ok && !inc) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

endmodule

// File: rtl/kamacore_scoreboard.sv
// Decode-stage issue controller: tracks in-flight register writes and
// decides each cycle whether the decoded instruction may go to execute.
//   clk, rst : clock, async active-low reset
//   sb       : kamacore_scoreboard_if.slave (decode/ex/wb handshake,
//              id_ready/issue/stall decision, stall_cnt, sticky sb_err)
// Optional: define KAMACORE_SCOREBOARD_BYPASS_EN to let a consumer issue in
// the same cycle its last outstanding producer retires.
module kamacore_scoreboard
    import kamacore_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH,
    parameter int unsigned STALL_CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    kamacore_scoreboard_if.slave sb
);

`ifdef KAMACORE_SCOREBOARD_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    sb_state_t state_q, state_d;

    logic [REG_COUNT-1:1] inc_v, dec_v, uflow_v;
    logic [REG_COUNT-1:0] zero_v, max_v, one_v;

    logic rs1_busy_c, rs2_busy_c, waw_c;
    logic id_ready_c, issue_c, stall_c;

    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;
    logic                       sb_err_q;

    // x0 is never tracked: always empty, never full
    assign zero_v[0] = 1'b1;
    assign max_v[0]  = 1'b0;
    assign one_v[0]  = 1'b0;

    // one counter per tracked register; retires in the flush cycle are dropped
    for (genvar i = 1; i < REG_COUNT; i++) begin : g_cnt
        assign inc_v[i] = issue_c & sb.id_rd_we & (sb.id_rd_a == REG_ADDR_WIDTH'(i));
        assign dec_v[i] = sb.wb_rd_we & ~sb.flush & (sb.wb_rd_a == REG_ADDR_WIDTH'(i));

        kamacore_sb_counter #(.W(CNT_WIDTH)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_v[i]),
            .dec       (dec_v[i]),
            .clear     (sb.flush),
            .is_zero   (zero_v[i]),
            .is_max    (max_v[i]),
            .is_one    (one_v[i]),
            .underflow (uflow_v[i])
        );
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; flush overrides everything, FLUSH lasts one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (sb.flush)    state_d = FLUSH;
                else if (stall_c) state_d = STALL;
            end
            STALL: begin
                if (sb.flush)     state_d = FLUSH;
                else if (issue_c) state_d = RUN;
                else if (stall_c) state_d = STALL;
                else              state_d = RUN;
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Hazard check and issue decision, same cycle as the decoded instruction
    always_comb begin
        rs1_busy_c = 1'b0;
        rs2_busy_c = 1'b0;
        waw_c      = 1'b0;
        if (sb.id_rs1_used && sb.id_rs1_a != '0) begin
            rs1_busy_c = ~zero_v[sb.id_rs1_a]
                       & ~(BYPASS_EN & one_v[sb.id_rs1_a] & sb.wb_rd_we
                           & (sb.wb_rd_a == sb.id_rs1_a));
        end
        if (sb.id_rs2_used && sb.id_rs2_a != '0) begin
            rs2_busy_c = ~zero_v[sb.id_rs2_a]
                       & ~(BYPASS_EN & one_v[sb.id_rs2_a] & sb.wb_rd_we
                           & (sb.wb_rd_a == sb.id_rs2_a));
        end
        if (sb.id_rd_we && sb.id_rd_a != '0) begin
            waw_c = max_v[sb.id_rd_a];
        end
        id_ready_c = rst & (state_q != FLUSH) & sb.ex_ready & ~sb.flush
                   & ~(rs1_busy_c | rs2_busy_c | waw_c);
        issue_c    = sb.id_valid & id_ready_c;
        stall_c    = rst & sb.id_valid & ~id_ready_c;
    end

    // Saturating stall counter and sticky underflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            if (stall_c && !(&stall_cnt_q)) begin
                stall_cnt_q <= stall_cnt_q + STALL_CNT_WIDTH'(1);
            end
            if (|uflow_v) begin
                sb_err_q <= 1'b1;
            end
        end
    end

    assign sb.id_ready  = id_ready_c;
    assign sb.issue     = issue_c;
    assign sb.stall     = stall_c;
    assign sb.stall_cnt = stall_cnt_q;
    assign sb.sb_err    = sb_err_q;

endmodule
